alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Multi-cycle control FSM for the 16-bit CPU datapath.
- Fetches each instruction and decodes it to the ALU opcode, register addresses and immediate.
- Sequences register-file read, ALU, memory access and writeback, and owns the PSR flag register {Z,C,F,N,L}.
- Sits between instruction/data memory, register file and alu; one instruction in flight at a time.

Parameters:
MUL_CYCLES, 3, EXEC dwell for MUL/MULI when MULTICYCLE_MUL_EN is defined (range 1..15); ignored otherwise.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
instr  input  16  memory read data, captured into IR at fetch
mem_ready  input  1  memory completes current request this cycle
alu_flags  input  5  alu Flags {Z,C,F,N,L}
mem_req  output  1  memory request (FETCH and MEM states)
mem_we  output  1  store strobe (MEM state, STOR only)
addr_sel  output  1  0 = PC drives address, 1 = rf read port A (Rsrc)
pc_inc  output  1  one-cycle PC increment pulse
ir  output  16  instruction register
alu_opcode  output  5  opcode to alu
alu_b_sel  output  1  0 = register B, 1 = imm
imm  output  16  extended immediate
carry_in  output  1  flags_q[3], for ADDC/ADDCI
rf_ra  output  4  read port A address (Rdest)
rf_rb  output  4  read port B address (Rsrc)
rf_wa  output  4  write address (Rdest)
rf_we  output  1  register write strobe
wb_sel  output  1  0 = ALU result, 1 = memory data
flags_q  output  5  PSR {Z,C,F,N,L}
illegal  output  1  one-cycle pulse on undecodable instruction

Behaviour:
- Instruction fields: op = ir[15:12], Rdest = ir[11:8], opext = ir[7:4], Rsrc = ir[3:0], imm8 = ir[7:0].
- R-type (op 0000), selected by opext: AND 0001, OR 0010, XOR 0011, ADD 0101, ADDU 0110, ADDC 0111, SUB 1001, CMP 1011, CMPU 1000, MOV 1101, MUL 1110.
- I-type: op takes the same codes as those opexts (ANDI, ORI, XORI, ADDI, ADDUI, ADDCI, SUBI, CMPI, MOVI, MULI); CMPU has no immediate form.
- Memory ops (op 0100): LOAD opext 0000, STOR opext 0100.
- Any other op/opext combination is illegal.
- Immediate extension: zero-extend imm8 for ANDI, ORI, XORI, ADDUI, MOVI; sign-extend imm8 for all other I-type ops.
- States and transitions:
  - FETCH: mem_req=1, addr_sel=0. Hold while mem_ready=0. On mem_ready=1: ir<=instr, pc_inc=1, go to DECODE.
  - DECODE: illegal → illegal=1, go to FETCH. LOAD/STOR → MEM. Everything else → EXEC.
  - EXEC: drive alu_opcode/alu_b_sel/imm. Go to WB, except CMP/CMPI/CMPU → FETCH.
  - MEM: mem_req=1, addr_sel=1, mem_we=1 for STOR. Hold while mem_ready=0. On mem_ready=1: LOAD → WB, STOR → FETCH.
  - WB: rf_we=1, wb_sel = 1 for LOAD else 0; then FETCH.
- Minimum latency with mem_ready tied high: ALU op 4 cycles, CMP 3, LOAD 4, STOR 3.
- Flag update on the final EXEC cycle, from alu_flags:
  - ADD/ADDU/ADDC/SUB (and immediate forms) update C and F only.
  - CMP/CMPU/CMPI update Z, N and L only.
  - AND/OR/XOR/MOV/MUL update nothing.
  - Unmasked bits hold their value.
- Decode outputs (rf_ra, rf_rb, rf_wa, alu_opcode, imm, alu_b_sel) are combinational from ir and stay stable from DECODE through WB.
- Strobes (rf_we, mem_we, pc_inc, illegal) are asserted only in the states listed above; all are Moore outputs except pc_inc.
- Reset, asserted at any time including mid-MEM with mem_ready=0: state=FETCH, ir=0, flags_q=0, all strobes 0, mem_req=1 once reset releases.
- mem_ready high on the same edge as reset release is ignored; the first fetch completes no earlier than the first edge after release.

Optional Feature:
MULTICYCLE_MUL_EN:
- Defined: a 4-bit counter holds MUL/MULI in EXEC for exactly MUL_CYCLES cycles; outputs stay stable while held; WB follows the last cycle.
- Undefined: MUL/MULI spend 1 EXEC cycle and no counter is synthesised.

Decomposition:
- Package cpu_pkg: op/opext codes, 5-bit alu opcode constants, state enum, flag bit indices (Z=4, C=3, F=2, N=1, L=0), per-op flag-write masks. The alu shares the same constants.
- Sub-module alu_seq_decode: purely combinational ir → alu_opcode, imm, alu_b_sel, flag mask, class (rtype/itype/load/stor/cmp/illegal). The FSM stays in alu_seq_ctrl.

Test Plan:
- instr=16'h0354 (ADD R3,R4), mem_ready=1 → rf_ra=3, rf_rb=4, alu_opcode=ADD, rf_we=1 with rf_wa=3 in cycle 4, then mem_req=1 again.
- instr=16'h52FF (ADDI R2,#-1) → imm=16'hFFFF, alu_b_sel=1; alu_flags=5'b01100 → flags_q=5'b01100.
- instr=16'h01B2 (CMP R1,R2), alu_flags=5'b00011, prior flags_q=5'b01100 → flags_q=5'b01111, rf_we never asserted, back to FETCH after 3 cycles.
- instr=16'h4506 (LOAD R5,(R6)), mem_ready held 0 for 3 cycles in MEM → mem_req=1, addr_sel=1 held throughout; then WB with wb_sel=1, rf_wa=5. Repeat with 16'h4546 → mem_we=1, no WB.
- instr=16'hC000 → illegal pulses exactly one cycle in DECODE, no rf_we/mem_we, next FETCH follows.
- rst_n dropped mid-MEM → immediate FETCH, flags_q=0, mem_we=0. With MULTICYCLE_MUL_EN and MUL_CYCLES=3, instr=16'h03E4 → EXEC lasts exactly 3 cycles.

Source files
------------

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared CPU constants: op/opext codes, 5-bit ALU opcodes, FSM states,
// decode classes, PSR flag indices and per-op flag-write masks.
// The alu uses the same constants, so keep encodings in sync with it.
package cpu_pkg;
  localparam logic [3:0] OP_RTYPE = 4'h0, OP_MEM = 4'h4;
  localparam logic [3:0] X_LOAD = 4'h0, X_STOR = 4'h4;
  localparam logic [3:0] C_AND = 4'h1, C_OR = 4'h2, C_XOR = 4'h3, C_ADD = 4'h5,
                         C_ADDU = 4'h6, C_ADDC = 4'h7, C_CMPU = 4'h8, C_SUB = 4'h9,
                         C_CMP = 4'hB, C_MOV = 4'hD, C_MUL = 4'hE;

  localparam logic [4:0] ALU_NOP = 5'd0, ALU_AND = 5'd1, ALU_OR = 5'd2, ALU_XOR = 5'd3,
                         ALU_ADD = 5'd5, ALU_ADDU = 5'd6, ALU_ADDC = 5'd7, ALU_CMPU = 5'd8,
                         ALU_SUB = 5'd9, ALU_CMP = 5'd11, ALU_MOV = 5'd13, ALU_MUL = 5'd14;

  localparam int FLAG_Z = 4, FLAG_C = 3, FLAG_F = 2, FLAG_N = 1, FLAG_L = 0;
  localparam logic [4:0] MASK_ARITH = 5'b01100;  // C,F
  localparam logic [4:0] MASK_CMP   = 5'b10011;  // Z,N,L
  localparam logic [4:0] MASK_NONE  = 5'b00000;

  typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB} state_e;
  typedef enum logic [2:0] {CLS_RTYPE, CLS_ITYPE, CLS_LOAD, CLS_STOR, CLS_ILLEGAL} cls_e;

  // ALU_NOP doubles as "no such operation"
  function automatic logic [4:0] alu_op_of(input logic [3:0] c);
    case (c)
      C_AND:  return ALU_AND;
      C_OR:   return ALU_OR;
      C_XOR:  return ALU_XOR;
      C_ADD:  return ALU_ADD;
      C_ADDU: return ALU_ADDU;
      C_ADDC: return ALU_ADDC;
      C_CMPU: return ALU_CMPU;
      C_SUB:  return ALU_SUB;
      C_CMP:  return ALU_CMP;
      C_MOV:  return ALU_MOV;
      C_MUL:  return ALU_MUL;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic logic [4:0] mask_of(input logic [3:0] c);
    case (c)
      C_ADD, C_ADDU, C_ADDC, C_SUB: return MASK_ARITH;
      C_CMP, C_CMPU:                return MASK_CMP;
      default:                      return MASK_NONE;
    endcase
  endfunction
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Memory bus between the control FSM and instruction/data memory.
//   instr     : memory read data (captured into IR at fetch)
//   mem_ready : memory completes the current request this cycle
//   mem_req   : request strobe
//   mem_we    : store strobe
//   addr_sel  : 0 = PC drives address, 1 = register read port A
interface alu_seq_ctrl_if;
  logic [15:0] instr;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;

  modport master (input instr, mem_ready, output mem_req, mem_we, addr_sel);
  modport slave  (output instr, mem_ready, input mem_req, mem_we, addr_sel);
endinterface

// File: rtl/alu_seq_ctrl_decode.sv
// alu_seq_decode: combinational instruction decode.
//   ir         : instruction register
//   alu_opcode : ALU operation (ALU_NOP for memory/illegal)
//   imm        : zero/sign-extended imm8
//   alu_b_sel  : 1 for I-type (imm feeds ALU B)
//   flag_mask  : PSR bits this op is allowed to write
//   cls        : rtype/itype/load/stor/illegal
//   is_cmp     : CMP/CMPU/CMPI (no writeback)
module alu_seq_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [4:0]  alu_opcode,
  output logic [15:0] imm,
  output logic        alu_b_sel,
  output logic [4:0]  flag_mask,
  output cls_e        cls,
  output logic        is_cmp
);
  logic [3:0] op, ext, code;
  logic [4:0] aop;

  always_comb begin
    op         = ir[15:12];
    ext        = ir[7:4];
    // I-type ops reuse the R-type opext encodings in the op field
    code       = (op == OP_RTYPE) ? ext : op;
    aop        = alu_op_of(code);
    cls        = CLS_ILLEGAL;
    alu_opcode = ALU_NOP;
    alu_b_sel  = 1'b0;
    flag_mask  = MASK_NONE;
    is_cmp     = 1'b0;
    if (op == OP_MEM) begin
      if (ext == X_LOAD)      cls = CLS_LOAD;
      else if (ext == X_STOR) cls = CLS_STOR;
    end else if (aop != ALU_NOP && !(op != OP_RTYPE && code == C_CMPU)) begin
      cls        = (op == OP_RTYPE) ? CLS_RTYPE : CLS_ITYPE;
      alu_opcode = aop;
      alu_b_sel  = (op != OP_RTYPE);
      flag_mask  = mask_of(code);
      is_cmp     = (code == C_CMP) || (code == C_CMPU);
    end
    case (op)
      C_AND, C_OR, C_XOR, C_ADDU, C_MOV: imm = {8'h00, ir[7:0]};
      default:                           imm = {{8{ir[7]}}, ir[7:0]};
    endcase
  end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle control FSM for the 16-bit datapath.
// FETCH -> DECODE -> EXEC/MEM -> WB -> FETCH, one instruction in flight.
// Owns IR and the PSR flags {Z,C,F,N,L}.
// Ports: clk, rst_n (async low); bus (memory, master modport);
//   alu_flags in; pc_inc, ir, alu_opcode, alu_b_sel, imm, carry_in,
//   rf_ra/rf_rb/rf_wa, rf_we, wb_sel, flags_q, illegal out.
// Option: `define MULTICYCLE_MUL_EN holds MUL/MULI in EXEC for MUL_CYCLES.
module alu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_seq_ctrl_if.master        bus,
  input  logic [4:0]            alu_flags,
  output logic                  pc_inc,
  output logic [15:0]           ir,
  output logic [4:0]            alu_opcode,
  output logic                  alu_b_sel,
  output logic [15:0]           imm,
  output logic                  carry_in,
  output logic [3:0]            rf_ra,
  output logic [3:0]            rf_rb,
  output logic [3:0]            rf_wa,
  output logic                  rf_we,
  output logic                  wb_sel,
  output logic [4:0]            flags_q,
  output logic                  illegal
);
  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
    $error("MUL_CYCLES must be 1..15");
  end

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [4:0]  flags_d, flag_mask;
  cls_e        cls;
  logic        is_cmp, is_mem, exec_done;
  logic        mem_req_o, mem_we_o, addr_sel_o;

  alu_seq_decode u_dec (
    .ir         (ir_q),
    .alu_opcode (alu_opcode),
    .imm        (imm),
    .alu_b_sel  (alu_b_sel),
    .flag_mask  (flag_mask),
    .cls        (cls),
    .is_cmp     (is_cmp)
  );

  assign is_mem = (cls == CLS_LOAD) || (cls == CLS_STOR);
  // Memory ops address through port A, so it carries Rsrc and port B
  // carries the store data register Rdest.
  assign rf_ra    = is_mem ? ir_q[3:0]  : ir_q[11:8];
  assign rf_rb    = is_mem ? ir_q[11:8] : ir_q[3:0];
  assign rf_wa    = ir_q[11:8];
  assign ir       = ir_q;
  assign carry_in = flags_q[FLAG_C];
  assign bus.mem_req  = mem_req_o;
  assign bus.mem_we   = mem_we_o;
  assign bus.addr_sel = addr_sel_o;

`ifdef MULTICYCLE_MUL_EN
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
  logic [3:0] mul_cnt_q, mul_cnt_d;

  always_comb begin
    mul_cnt_d = '0;
    exec_done = 1'b1;
    if (state_q == ST_EXEC && alu_opcode == ALU_MUL && mul_cnt_q != MUL_LAST) begin
      mul_cnt_d = mul_cnt_q + 4'd1;
      exec_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mul_cnt_q <= '0;
    else        mul_cnt_q <= mul_cnt_d;
`else
  assign exec_done = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    flags_d    = flags_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    addr_sel_o = 1'b0;
    pc_inc     = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (bus.mem_ready) begin
          ir_d    = bus.instr;
          // Mealy pulse; masked so it stays low while reset is held
          pc_inc  = rst_n;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls == CLS_ILLEGAL) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else if (is_mem) state_d = ST_MEM;
        else                 state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) begin
          flags_d = (flags_q & ~flag_mask) | (alu_flags & flag_mask);
          state_d = is_cmp ? ST_FETCH : ST_WB;
        end
      end
      ST_MEM: begin
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        mem_we_o   = (cls == CLS_STOR);
        if (bus.mem_ready) state_d = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        rf_we   = 1'b1;
        wb_sel  = (cls == CLS_LOAD);
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  alu_flags;
  logic        pc_inc, alu_b_sel, carry_in, rf_we, wb_sel, illegal;
  logic [15:0] ir, imm;
  logic [4:0]  alu_opcode, flags_q;
  logic [3:0]  rf_ra, rf_rb, rf_wa;
  int total = 0;
  int passed = 0;

`ifdef MULTICYCLE_MUL_EN
  localparam int EXP_MUL = 3;
`else
  localparam int EXP_MUL = 1;
`endif

  alu_seq_ctrl_if bus_if ();

  alu_seq_ctrl #(.MUL_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if), .alu_flags(alu_flags),
    .pc_inc(pc_inc), .ir(ir), .alu_opcode(alu_opcode), .alu_b_sel(alu_b_sel),
    .imm(imm), .carry_in(carry_in), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa),
    .rf_we(rf_we), .wb_sel(wb_sel), .flags_q(flags_q), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Every task starts and ends at a negedge with the DUT in FETCH.
  task automatic test_reset();
    rst_n = 1'b0; bus_if.mem_ready = 1'b1; bus_if.instr = 16'h0354; alu_flags = '0;
    repeat (2) @(negedge clk);
    total++; if ({bus_if.mem_req, bus_if.addr_sel, bus_if.mem_we, rf_we, pc_inc, illegal} !== 6'b100000)
      $display("FAIL reset_strobes: got %b want 100000", {bus_if.mem_req, bus_if.addr_sel, bus_if.mem_we, rf_we, pc_inc, illegal}); else passed++;
    total++; if ({ir, flags_q} !== 21'd0) $display("FAIL reset_regs: got ir=%h flags=%b want 0", ir, flags_q); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    bus_if.instr = 16'h0354; bus_if.mem_ready = 1'b1; alu_flags = 5'b00000; #1;
    total++; if ({bus_if.mem_req, pc_inc} !== 2'b11) $display("FAIL add_fetch: got %b want 11", {bus_if.mem_req, pc_inc}); else passed++;
    @(negedge clk);
    total++; if ({ir, rf_ra, rf_rb, alu_opcode, alu_b_sel, bus_if.mem_req, rf_we} !== {16'h0354, 4'd3, 4'd4, 5'd5, 3'b000})
      $display("FAIL add_decode: got ir=%h ra=%0d rb=%0d op=%0d", ir, rf_ra, rf_rb, alu_opcode); else passed++;
    @(negedge clk);
    total++; if ({bus_if.mem_req, rf_we, pc_inc} !== 3'b000) $display("FAIL add_exec: got %b want 000", {bus_if.mem_req, rf_we, pc_inc}); else passed++;
    @(negedge clk);
    total++; if ({rf_we, rf_wa, wb_sel} !== {1'b1, 4'd3, 1'b0}) $display("FAIL add_wb: got we=%b wa=%0d sel=%b want 1 3 0", rf_we, rf_wa, wb_sel); else passed++;
    @(negedge clk);
    total++; if ({bus_if.mem_req, rf_we, flags_q} !== {2'b10, 5'b00000}) $display("FAIL add_next_fetch: got req=%b we=%b flags=%b", bus_if.mem_req, rf_we, flags_q); else passed++;
  endtask

  task automatic test_imm_ext();
    logic [15:0] ins [2] = '{16'h17F0, 16'h9380};
    logic [21:0] exp [2] = '{{16'h00F0, 1'b1, 5'd1}, {16'hFF80, 1'b1, 5'd9}};
    alu_flags = 5'b00000;
    for (int i = 0; i < 2; i++) begin
      bus_if.instr = ins[i];
      @(negedge clk);
      total++; if ({imm, alu_b_sel, alu_opcode} !== exp[i]) $display("FAIL imm_ext%0d: got %h want %h", i, {imm, alu_b_sel, alu_opcode}, exp[i]); else passed++;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_addi();
    bus_if.instr = 16'h52FF; alu_flags = 5'b01100;
    @(negedge clk);
    total++; if ({imm, alu_b_sel, alu_opcode, rf_ra} !== {16'hFFFF, 1'b1, 5'd5, 4'd2}) $display("FAIL addi_decode: got imm=%h bsel=%b op=%0d", imm, alu_b_sel, alu_opcode); else passed++;
    @(negedge clk);
    total++; if (flags_q !== 5'b00000) $display("FAIL addi_flags_early: got %b want 00000", flags_q); else passed++;
    @(negedge clk);
    total++; if ({rf_we, rf_wa, flags_q} !== {1'b1, 4'd2, 5'b01100}) $display("FAIL addi_wb: got we=%b wa=%0d flags=%b want 1 2 01100", rf_we, rf_wa, flags_q); else passed++;
    @(negedge clk);
  endtask

  task automatic test_cmp();
    bus_if.instr = 16'h01B2; alu_flags = 5'b00011;
    @(negedge clk);
    total++; if ({rf_ra, rf_rb, alu_opcode, rf_we} !== {4'd1, 4'd2, 5'd11, 1'b0}) $display("FAIL cmp_decode: got ra=%0d rb=%0d op=%0d", rf_ra, rf_rb, alu_opcode); else passed++;
    @(negedge clk);
    total++; if (rf_we !== 1'b0) $display("FAIL cmp_exec_we: got %b want 0", rf_we); else passed++;
    @(negedge clk);
    total++; if ({bus_if.mem_req, rf_we, flags_q} !== {2'b10, 5'b01111}) $display("FAIL cmp_fetch: got req=%b we=%b flags=%b want 1 0 01111", bus_if.mem_req, rf_we, flags_q); else passed++;
  endtask

  task automatic test_flag_mask();
    bus_if.instr = 16'h0354; alu_flags = 5'b00000;
    repeat (4) @(negedge clk);
    total++; if (flags_q !== 5'b00011) $display("FAIL mask_add: got %b want 00011", flags_q); else passed++;
    bus_if.instr = 16'h0112; alu_flags = 5'b11111;
    repeat (4) @(negedge clk);
    total++; if ({flags_q, carry_in} !== {5'b00011, 1'b0}) $display("FAIL mask_and: got %b want 000110", {flags_q, carry_in}); else passed++;
  endtask

  task automatic test_mul();
    int n = 0;
    bit done = 1'b0;
    bus_if.instr = 16'h03E4; alu_flags = 5'b11111;
    @(negedge clk);
    total++; if (alu_opcode !== 5'd14) $display("FAIL mul_decode: got %0d want 14", alu_opcode); else passed++;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (rf_we === 1'b1) done = 1'b1; else n++;
    end
    total++; if (done !== 1'b1) $display("FAIL mul_wb_timeout: got %b want 1", done); else passed++;
    total++; if (n !== EXP_MUL) $display("FAIL mul_exec_cycles: got %0d want %0d", n, EXP_MUL); else passed++;
    total++; if ({rf_wa, flags_q} !== {4'd3, 5'b00011}) $display("FAIL mul_wb: got wa=%0d flags=%b want 3 00011", rf_wa, flags_q); else passed++;
    @(negedge clk);
  endtask

  task automatic test_load();
    bus_if.instr = 16'h4506;
    @(negedge clk);
    bus_if.mem_ready = 1'b0;
    total++; if ({bus_if.mem_req, alu_opcode} !== {1'b0, 5'd0}) $display("FAIL load_decode: got req=%b op=%0d", bus_if.mem_req, alu_opcode); else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if ({bus_if.mem_req, bus_if.addr_sel, bus_if.mem_we, rf_we} !== 4'b1100) $display("FAIL load_mem%0d: got %b want 1100", i, {bus_if.mem_req, bus_if.addr_sel, bus_if.mem_we, rf_we}); else passed++;
    end
    bus_if.mem_ready = 1'b1;
    @(negedge clk);
    total++; if ({rf_we, wb_sel, rf_wa, bus_if.mem_req} !== {2'b11, 4'd5, 1'b0}) $display("FAIL load_wb: got we=%b sel=%b wa=%0d req=%b", rf_we, wb_sel, rf_wa, bus_if.mem_req); else passed++;
    @(negedge clk);
    total++; if ({bus_if.mem_req, bus_if.addr_sel} !== 2'b10) $display("FAIL load_fetch: got %b want 10", {bus_if.mem_req, bus_if.addr_sel}); else passed++;
  endtask

  task automatic test_stor();
    bus_if.instr = 16'h4546;
    repeat (2) @(negedge clk);
    total++; if ({bus_if.mem_req, bus_if.addr_sel, bus_if.mem_we, rf_we} !== 4'b1110) $display("FAIL stor_mem: got %b want 1110", {bus_if.mem_req, bus_if.addr_sel, bus_if.mem_we, rf_we}); else passed++;
    @(negedge clk);
    total++; if ({bus_if.mem_req, bus_if.addr_sel, bus_if.mem_we, rf_we} !== 4'b1000) $display("FAIL stor_fetch: got %b want 1000", {bus_if.mem_req, bus_if.addr_sel, bus_if.mem_we, rf_we}); else passed++;
  endtask

  task automatic test_illegal();
    logic [15:0] ins [3] = '{16'hC000, 16'h8012, 16'h4516};
    for (int i = 0; i < 3; i++) begin
      bus_if.instr = ins[i];
      @(negedge clk);
      total++; if ({illegal, rf_we, bus_if.mem_we} !== 3'b100) $display("FAIL illegal_dec%0d: got %b want 100", i, {illegal, rf_we, bus_if.mem_we}); else passed++;
      @(negedge clk);
      total++; if ({illegal, bus_if.mem_req, flags_q} !== {2'b01, 5'b00011}) $display("FAIL illegal_next%0d: got %b want 0100011", i, {illegal, bus_if.mem_req, flags_q}); else passed++;
    end
  endtask

  task automatic test_reset_mid_mem();
    bus_if.instr = 16'h4546;
    @(negedge clk);
    bus_if.mem_ready = 1'b0;
    @(negedge clk);
    total++; if (bus_if.mem_we !== 1'b1) $display("FAIL rstmem_pre: got %b want 1", bus_if.mem_we); else passed++;
    @(negedge clk);
    rst_n = 1'b0; #1;
    total++; if ({bus_if.mem_req, bus_if.addr_sel, bus_if.mem_we, rf_we, pc_inc, illegal} !== 6'b100000)
      $display("FAIL rstmem_strobes: got %b want 100000", {bus_if.mem_req, bus_if.addr_sel, bus_if.mem_we, rf_we, pc_inc, illegal}); else passed++;
    total++; if ({ir, flags_q} !== 21'd0) $display("FAIL rstmem_regs: got ir=%h flags=%b want 0", ir, flags_q); else passed++;
    bus_if.mem_ready = 1'b1;
    @(negedge clk);
    total++; if ({pc_inc, ir} !== 17'd0) $display("FAIL rstmem_held: got pc_inc=%b ir=%h want 0", pc_inc, ir); else passed++;
    rst_n = 1'b1; #1;
    total++; if ({bus_if.mem_req, pc_inc} !== 2'b11) $display("FAIL rstmem_release: got %b want 11", {bus_if.mem_req, pc_inc}); else passed++;
    @(negedge clk);
    total++; if (ir !== 16'h4546) $display("FAIL rstmem_refetch: got %h want 4546", ir); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm_ext();
    test_addi();
    test_cmp();
    test_flag_mask();
    test_mul();
    test_load();
    test_stor();
    test_illegal();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
